// File: rtl/stream_upsize_id_pkg.sv
// Shared types and helpers for the ID-aware stream upsizer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: default lane count, accumulator state encoding, counter width
// helpers and the lane-count-to-keep-mask function.
package stream_upsize_pkg;

    // Lane count used when the block is instantiated with default parameters.
    localparam int DEFAULT_RATIO = 4;

    // Accumulator occupancy:
    //   ACC_EMPTY : no lanes held
    //   ACC_FILL  : 1..RATIO-1 lanes held, word still open
    //   ACC_HELD  : a complete single-lane word that could not go out yet
    typedef enum logic [1:0] {
        ACC_EMPTY = 2'd0,
        ACC_FILL  = 2'd1,
        ACC_HELD  = 2'd2
    } acc_state_e;

    // Lane counter width, $clog2(ratio); kept at one bit minimum.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Idle counter width, $clog2(timeout+1); one bit when the timeout is off.
    function automatic int idle_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Contiguous keep mask with the low n lanes set (2^n - 1).
    function automatic logic [31:0] keep_from_count(input int n);
        if (n >= 32) begin
            return '1;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/stream_upsize_id_if.sv
// Bundles the narrow input stream and wide output stream of the upsizer.
// Latency: n/a (wires only).
// Backpressure: s_ready_o / m_ready_i valid-ready handshakes.
//
// Ports: s_data_i/s_id_i/s_last_i/s_valid_i/s_ready_o form the narrow input,
// m_data_o[lanes]/m_keep_o/m_id_o/m_last_o/m_valid_o/m_ready_i the wide output.
// Modport slave is the upsizer's view; master is the view of the logic
// around it (producer driving s_*, consumer driving m_ready_i).
interface stream_upsize_id_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 4,
    parameter int T_ID_WIDTH   = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic [T_ID_WIDTH-1:0]   s_id_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] m_keep_o;
    logic [T_ID_WIDTH-1:0]   m_id_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_id_i, s_last_i, s_valid_i,
        output s_ready_o,
        output m_data_o, m_keep_o, m_id_o, m_last_o, m_valid_o,
        input  m_ready_i
    );

    modport master (
        output s_data_i, s_id_i, s_last_i, s_valid_i,
        input  s_ready_o,
        input  m_data_o, m_keep_o, m_id_o, m_last_o, m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/stream_pack_acc.sv
// Accumulates narrow beats into lanes and decides when a word leaves.
// Latency: word presented combinationally on out_* in the cycle it completes.
// Backpressure: out_load only asserted when out_free; otherwise the word waits.
//
// Ports: beat_* is the input beat and beat_acc its acceptance strobe;
// out_free says the output register can take a word this cycle; out_load
// plus out_data/out_keep/out_id/out_last carry the word to load;
// acc_empty/acc_held report occupancy for the ready logic.
module stream_pack_acc
    import stream_upsize_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 4,
    parameter int T_DATA_RATIO  = DEFAULT_RATIO,
    parameter int T_ID_WIDTH    = 2,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] beat_data,
    input  logic [T_ID_WIDTH-1:0]   beat_id,
    input  logic                    beat_last,
    input  logic                    beat_acc,
    input  logic                    out_free,
    output logic                    acc_empty,
    output logic                    acc_held,
    output logic                    out_load,
    output logic [T_DATA_WIDTH-1:0] out_data [T_DATA_RATIO],
    output logic [T_DATA_RATIO-1:0] out_keep,
    output logic [T_ID_WIDTH-1:0]   out_id,
    output logic                    out_last
);
    localparam int CW = cnt_width(T_DATA_RATIO);
    localparam int IW = idle_width(FLUSH_TIMEOUT);
    localparam logic [CW-1:0] CNT_TOP  = CW'(T_DATA_RATIO - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);
    localparam bit            TIMEOUT_EN = (FLUSH_TIMEOUT != 0);

    acc_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [T_DATA_WIDTH-1:0] lanes_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] lanes_d [T_DATA_RATIO];
    logic [T_ID_WIDTH-1:0]   id_q, id_d;
    logic [IW-1:0]           idle_q, idle_d;

    logic id_chg;
    logic at_top;
    logic timeout_hit;

    assign acc_empty = (state_q == ACC_EMPTY);
    assign acc_held  = (state_q == ACC_HELD);

    // A held word never coexists with acceptance (ready is low), so the ID
    // comparison only matters while a word is still open.
    assign id_chg      = beat_acc && (state_q == ACC_FILL) && (beat_id != id_q);
    assign at_top      = (cnt_q == CNT_TOP);
    assign timeout_hit = TIMEOUT_EN && (state_q == ACC_FILL) && (idle_q == IDLE_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lanes_d  = lanes_q;
        id_d     = id_q;
        idle_d   = idle_q;
        out_load = 1'b0;
        out_data = lanes_q;
        out_keep = T_DATA_RATIO'(keep_from_count(int'(cnt_q)));
        out_id   = id_q;
        out_last = 1'b0;

        if (state_q == ACC_HELD) begin
            // Complete one-lane word parked earlier; it always closes a packet.
            out_keep = T_DATA_RATIO'(keep_from_count(1));
            out_last = 1'b1;
            if (out_free) begin
                out_load = 1'b1;
                state_d  = ACC_EMPTY;
                cnt_d    = '0;
                lanes_d  = '{default: '0};
            end
        end else if (beat_acc) begin
            if (id_chg) begin
                // Close the open word as-is; the new beat starts a fresh one.
                // Acceptance with a non-empty accumulator implies out_free.
                out_load   = 1'b1;
                lanes_d    = '{default: '0};
                lanes_d[0] = beat_data;
                id_d       = beat_id;
                cnt_d      = beat_last ? CW'(0) : CW'(1);
                state_d    = beat_last ? ACC_HELD : ACC_FILL;
            end else if (beat_last || at_top) begin
                if (out_free) begin
                    out_load           = 1'b1;
                    out_data[cnt_q]    = beat_data;
                    out_keep           = T_DATA_RATIO'(keep_from_count(int'(cnt_q) + 1));
                    out_id             = beat_id;
                    out_last           = beat_last;
                    state_d            = ACC_EMPTY;
                    cnt_d              = '0;
                    lanes_d            = '{default: '0};
                end else begin
                    // Only reachable from empty: a single-beat packet absorbed
                    // while the output is still occupied.
                    lanes_d[0] = beat_data;
                    id_d       = beat_id;
                    cnt_d      = '0;
                    state_d    = ACC_HELD;
                end
            end else begin
                lanes_d[cnt_q] = beat_data;
                cnt_d          = cnt_q + CW'(1);
                state_d        = ACC_FILL;
                if (state_q == ACC_EMPTY) begin
                    id_d = beat_id;
                end
            end
        end else if (timeout_hit && out_free) begin
            out_load = 1'b1;
            state_d  = ACC_EMPTY;
            cnt_d    = '0;
            lanes_d  = '{default: '0};
        end

        // Idle counter saturates at the timeout so an expiry that hits a busy
        // output stays pending until the output frees up.
        if (beat_acc || out_load) begin
            idle_d = '0;
        end else if (TIMEOUT_EN && (state_q == ACC_FILL) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_EMPTY;
            cnt_q   <= '0;
            lanes_q <= '{default: '0};
            id_q    <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            id_q    <= id_d;
            idle_q  <= idle_d;
        end
    end

endmodule

// File: rtl/stream_upsize_id.sv
// Packs T_DATA_RATIO narrow beats into one wide word with keep, ID and last.
// Latency: one edge from the completing beat (or flush) to m_valid_o.
// Backpressure: s_ready_o high while the output can drain or the accumulator
// is empty; words hold stable on m_* while m_ready_i is low.
//
// Ports: clk, rst_n (async active-low); bus is the slave view of
// stream_upsize_id_if carrying the narrow input and wide output streams.
module stream_upsize_id
    import stream_upsize_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 4,
    parameter int T_DATA_RATIO  = DEFAULT_RATIO,
    parameter int T_ID_WIDTH    = 2,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_upsize_id_if.slave bus
);
    logic                    rdy_en;
    logic                    out_free;
    logic                    s_ready;
    logic                    beat_acc;
    logic                    acc_empty;
    logic                    acc_held;
    logic                    out_load;
    logic [T_DATA_WIDTH-1:0] out_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] out_keep;
    logic [T_ID_WIDTH-1:0]   out_id;
    logic                    out_last;

    logic [T_DATA_WIDTH-1:0] m_data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] m_keep_q;
    logic [T_ID_WIDTH-1:0]   m_id_q;
    logic                    m_last_q;
    logic                    m_valid_q;

    // Ready is held low during reset and comes up on the first edge after
    // release so no beat is taken while the state is still settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign out_free = !m_valid_q || bus.m_ready_i;
    // Ready uses occupancy only, never the beat contents. A held word blocks
    // input so two words never compete for the output in one cycle.
    assign s_ready  = rdy_en && (out_free || acc_empty) && !acc_held;
    assign beat_acc = bus.s_valid_i && s_ready;

    stream_pack_acc #(
        .T_DATA_WIDTH  (T_DATA_WIDTH),
        .T_DATA_RATIO  (T_DATA_RATIO),
        .T_ID_WIDTH    (T_ID_WIDTH),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_data (bus.s_data_i),
        .beat_id   (bus.s_id_i),
        .beat_last (bus.s_last_i),
        .beat_acc  (beat_acc),
        .out_free  (out_free),
        .acc_empty (acc_empty),
        .acc_held  (acc_held),
        .out_load  (out_load),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    // Output register: loads only when free, so a stalled word stays intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q  <= '{default: '0};
            m_keep_q  <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else if (out_load) begin
            m_data_q  <= out_data;
            m_keep_q  <= out_keep;
            m_id_q    <= out_id;
            m_last_q  <= out_last;
            m_valid_q <= 1'b1;
        end else if (bus.m_ready_i) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_keep_o  = m_keep_q;
    assign bus.m_id_o    = m_id_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_upsize_id.sv
// Scoreboard bench for stream_upsize_id: expected words come from a
// packet-level model of the packing rules; a monitor compares each word
// the DUT hands over. A second instance covers the disabled timeout.
module tb_stream_upsize_id;
    localparam int W   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [R-1:0][W-1:0] data;
        logic [R-1:0]        keep;
        logic [IDW-1:0]      id;
        logic                last;
    } word_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    word_t          exp_q[$];
    logic [W-1:0]   cur[$];
    logic [IDW-1:0] cur_id;
    word_t          mon_got;
    word_t          mon_exp;

    stream_upsize_id_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .T_ID_WIDTH(IDW)) bus ();
    stream_upsize_id_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .T_ID_WIDTH(IDW)) bus0 ();

    stream_upsize_id #(
        .T_DATA_WIDTH(W), .T_DATA_RATIO(R), .T_ID_WIDTH(IDW), .FLUSH_TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stream_upsize_id #(
        .T_DATA_WIDTH(W), .T_DATA_RATIO(R), .T_ID_WIDTH(IDW), .FLUSH_TIMEOUT(0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    // ---------------- reference model (packet rules) ----------------
    task automatic push_word(input logic last);
        word_t w;
        w = '0;
        for (int i = 0; i < cur.size(); i++) w.data[i] = cur[i];
        w.keep = R'((1 << cur.size()) - 1);
        w.id   = cur_id;
        w.last = last;
        exp_q.push_back(w);
        cur.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic [IDW-1:0] id, input logic last);
        if (cur.size() > 0 && id != cur_id) push_word(1'b0);
        if (cur.size() == 0) cur_id = id;
        cur.push_back(d);
        if (last || cur.size() == R) push_word(last);
    endtask

    task automatic model_flush();
        if (cur.size() > 0) push_word(1'b0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] d, input logic [IDW-1:0] id, input logic last,
                        output int waits);
        bit r;
        bit done;
        waits = 0;
        done  = 0;
        bus.s_data_i  = d;
        bus.s_id_i    = id;
        bus.s_last_i  = last;
        bus.s_valid_i = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            r = bus.s_ready_o;
            @(posedge clk);
            if (r) begin
                model_accept(d, id, last);
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL accept_bound: beat %0h not accepted after %0d cycles, required acceptance", d, waits);
        end
        #1;
        bus.s_valid_i = 1'b0;
    endtask

    task automatic send0(input logic [W-1:0] d, input logic last);
        bit r;
        bit done;
        done = 0;
        bus0.s_data_i  = d;
        bus0.s_id_i    = '0;
        bus0.s_last_i  = last;
        bus0.s_valid_i = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            r = bus0.s_ready_o;
            @(posedge clk);
            if (r) done = 1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL accept_bound0: beat %0h not accepted, required acceptance", d);
        end
        #1;
        bus0.s_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [R*W-1:0] pack_m();
        logic [R-1:0][W-1:0] v;
        for (int i = 0; i < R; i++) v[i] = bus.m_data_o[i];
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
            for (int i = 0; i < R; i++) mon_got.data[i] = bus.m_data_o[i];
            mon_got.keep = bus.m_keep_o;
            mon_got.id   = bus.m_id_o;
            mon_got.last = bus.m_last_o;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: actual %0h required no word", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("word", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int    w;
        int    tot;
        int    e;
        int    vcnt;
        bit    seen;
        word_t hold;
        logic [W-1:0]   rd;
        logic [IDW-1:0] rid;
        logic           rl;

        rst_n          = 1'b0;
        bus.s_valid_i  = 1'b0;
        bus.s_data_i   = '0;
        bus.s_id_i     = '0;
        bus.s_last_i   = 1'b0;
        bus.m_ready_i  = 1'b1;
        bus0.s_valid_i = 1'b0;
        bus0.s_data_i  = '0;
        bus0.s_id_i    = '0;
        bus0.s_last_i  = 1'b0;
        bus0.m_ready_i = 1'b1;
        cur_id         = '0;

        // Reset state
        #2;
        chk("rst_valid", 64'(bus.m_valid_o), 64'd0);
        chk("rst_keep_id_last", 64'({bus.m_keep_o, bus.m_id_o, bus.m_last_o}), 64'd0);
        chk("rst_data", 64'(pack_m()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_low", 64'(bus.s_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 64'(bus.s_ready_o), 64'd1);

        // Full word with last, latency one edge
        send(4'd1, 2'd0, 1'b0, w);
        send(4'd2, 2'd0, 1'b0, w);
        send(4'd3, 2'd0, 1'b0, w);
        send(4'd4, 2'd0, 1'b1, w);
        chk("latency_valid", 64'(bus.m_valid_o), 64'd1);
        idle(3);

        // ID change: partial word out, then held single-beat packet
        send(4'hA, 2'd1, 1'b0, w);
        send(4'hB, 2'd1, 1'b0, w);
        send(4'hC, 2'd2, 1'b1, w);
        idle(4);

        // Idle timeout flush of a partial word
        send(4'd5, 2'd0, 1'b0, w);
        send(4'd6, 2'd0, 1'b0, w);
        model_flush();
        e = 0;
        seen = 0;
        while (e < 20 && !seen) begin
            @(posedge clk);
            #1;
            e++;
            if (bus.m_valid_o) seen = 1;
        end
        chk("timeout_edges", 64'(e), 64'd9);
        idle(3);

        // Backpressure: full word stalled, one beat absorbed, then ready low
        bus.m_ready_i = 1'b0;
        send(4'd8,  2'd3, 1'b0, w);
        send(4'd9,  2'd3, 1'b0, w);
        send(4'd10, 2'd3, 1'b0, w);
        send(4'd11, 2'd3, 1'b0, w);
        send(4'd12, 2'd3, 1'b0, w);
        chk("bp_absorb_waits", 64'(w), 64'd0);
        hold = '0;
        hold.data[0] = 4'd8;
        hold.data[1] = 4'd9;
        hold.data[2] = 4'd10;
        hold.data[3] = 4'd11;
        bus.s_data_i  = 4'd13;
        bus.s_id_i    = 2'd3;
        bus.s_last_i  = 1'b0;
        bus.s_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_stall", 64'({bus.m_valid_o, bus.s_ready_o, bus.m_keep_o, pack_m()}),
                64'({1'b1, 1'b0, 4'b1111, hold.data}));
        end
        @(posedge clk);
        #1;
        bus.m_ready_i = 1'b1;
        send(4'd13, 2'd3, 1'b0, w);
        send(4'd14, 2'd3, 1'b0, w);
        send(4'd15, 2'd3, 1'b1, w);
        idle(3);

        // Reset while a word is pending and the accumulator is partly filled
        bus.m_ready_i = 1'b0;
        send(4'd3, 2'd1, 1'b0, w);
        send(4'd4, 2'd1, 1'b0, w);
        send(4'd5, 2'd1, 1'b0, w);
        send(4'd6, 2'd1, 1'b0, w);
        send(4'd7, 2'd1, 1'b0, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({bus.m_valid_o, bus.m_keep_o, bus.m_id_o, bus.m_last_o, pack_m()}), 64'd0);
        chk("midrst_ready", 64'(bus.s_ready_o), 64'd0);
        exp_q.delete();
        cur.delete();
        bus.m_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'd1, 2'd2, 1'b0, w);
        send(4'd2, 2'd2, 1'b0, w);
        send(4'd3, 2'd2, 1'b0, w);
        send(4'd4, 2'd2, 1'b1, w);
        idle(3);

        // Zero bubbles, including across an ID change
        tot = 0;
        for (int i = 0; i < 12; i++) begin
            send(W'(i), (i < 6) ? 2'd0 : 2'd1, 1'b0, w);
            tot += w;
        end
        model_flush();
        chk("zero_bubble", 64'(tot), 64'd0);
        idle(14);

        // Random stream
        rid = 2'd0;
        for (int i = 0; i < 64; i++) begin
            rd = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rid = IDW'($urandom_range(0, 3));
            rl = ($urandom_range(0, 7) == 0);
            send(rd, rid, rl, w);
            idle($urandom_range(0, 2));
        end
        model_flush();
        idle(15);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Timeout disabled: partial word must wait for more beats
        send0(4'd5, 1'b0);
        send0(4'd6, 1'b0);
        vcnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus0.m_valid_o) vcnt++;
        end
        chk("no_timeout_flush", 64'(vcnt), 64'd0);
        @(posedge clk);
        #1;
        send0(4'd7, 1'b1);
        hold = '0;
        hold.data[0] = 4'd5;
        hold.data[1] = 4'd6;
        hold.data[2] = 4'd7;
        begin
            logic [R-1:0][W-1:0] v0;
            for (int i = 0; i < R; i++) v0[i] = bus0.m_data_o[i];
            chk("t0_word", 64'({bus0.m_valid_o, bus0.m_keep_o, bus0.m_last_o, v0}),
                64'({1'b1, 4'b0111, 1'b1, hold.data}));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
